// File: rtl/branch_predictor_table.sv
// Gshare/bimodal branch direction predictor: a flop-based table of saturating counters
// with independent lookup and train ports, non-speculative global history and saturating stats.
module branch_predictor_table #(
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned HIST_BITS  = 4,
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned PC_LSB     = 2,
  parameter int unsigned STAT_BITS  = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       req_valid,
  input  logic [PC_BITS-1:0]                         req_pc,
  output logic                                       pred_valid,
  output logic                                       pred_taken,
  output logic [INDEX_BITS-1:0]                      pred_index,
  input  logic                                       upd_valid,
  input  logic [INDEX_BITS-1:0]                      upd_index,
  input  logic                                       upd_taken,
  input  logic                                       upd_pred,
  output logic [((HIST_BITS == 0) ? 1 : HIST_BITS)-1:0] ghist,
  output logic [STAT_BITS-1:0]                       stat_updates,
  output logic [STAT_BITS-1:0]                       stat_mispred
);

  localparam int unsigned GH_W    = (HIST_BITS == 0) ? 1 : HIST_BITS;
  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [INDEX_BITS-1:0] hist_ext;
  logic [INDEX_BITS-1:0] idx;
  logic [CTR_BITS-1:0]   upd_cur;
  logic [CTR_BITS-1:0]   upd_nxt;
  logic [GH_W-1:0]       ghist_nxt;
  logic                  mispred;
  logic                  unused_pc;

  // PC bits outside the index window are intentionally ignored.
  assign unused_pc = ^req_pc;

  assign hist_ext  = (HIST_BITS == 0) ? '0 : INDEX_BITS'(ghist);
  assign idx       = req_pc[PC_LSB +: INDEX_BITS] ^ hist_ext;
  assign ghist_nxt = (HIST_BITS == 0) ? '0 : GH_W'({ghist, upd_taken});
  assign mispred   = upd_taken != upd_pred;

  // Saturating counter step for the entry being trained.
  always_comb begin
    upd_cur = ctr_q[upd_index];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + CTR_BITS'(1);
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - CTR_BITS'(1);
    end
  end

  // Counter table: read-before-write, so a same-cycle lookup sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr_q[upd_index] <= upd_nxt;
    end
  end

  // Registered lookup result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= req_valid;
      if (req_valid) begin
        pred_index <= idx;
        pred_taken <= ctr_q[idx][CTR_BITS-1];
      end
    end
  end

  // Global history and statistics advance only on resolved branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghist        <= '0;
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (upd_valid) begin
      ghist <= ghist_nxt;
      if (stat_updates != STAT_MAX) stat_updates <= stat_updates + STAT_BITS'(1);
      if (mispred && (stat_mispred != STAT_MAX)) stat_mispred <= stat_mispred + STAT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: a gshare instance (HIST=4, STAT=4) and a bimodal
// instance (HIST=0, STAT=16) share stimulus and are checked against an array model.
module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic        upd_taken;
  logic        upd_pred;

  logic        pv0, pt0, pv1, pt1;
  logic [3:0]  pi0, pi1;
  logic [3:0]  gh0;
  logic [0:0]  gh1;
  logic [3:0]  su0, sm0;
  logic [15:0] su1, sm1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor_table #(.CTR_BITS(2), .INDEX_BITS(4), .HIST_BITS(4), .PC_BITS(32),
                           .PC_LSB(2), .STAT_BITS(4)) dut_g (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(pv0), .pred_taken(pt0), .pred_index(pi0),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghist(gh0), .stat_updates(su0), .stat_mispred(sm0));

  branch_predictor_table #(.CTR_BITS(2), .INDEX_BITS(4), .HIST_BITS(0), .PC_BITS(32),
                           .PC_LSB(2), .STAT_BITS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(pv1), .pred_taken(pt1), .pred_index(pi1),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghist(gh1), .stat_updates(su1), .stat_mispred(sm1));

  // Reference model: k=0 gshare, k=1 bimodal; counters held as integers 0..3.
  int m_ctr [2][16];
  int m_gh  [2];
  int m_su  [2];
  int m_sm  [2];
  int m_pi  [2];
  int m_pt  [2];
  int m_pv;
  int hist_len [2] = '{4, 0};
  int stat_max [2] = '{15, 65535};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int e = 0; e < 16; e++) m_ctr[k][e] = 1;
        m_gh[k] = 0; m_su[k] = 0; m_sm[k] = 0; m_pi[k] = 0; m_pt[k] = 0;
      end
      m_pv = 0;
    end else begin
      m_pv = int'(req_valid);
      for (int k = 0; k < 2; k++) begin
        if (req_valid) begin
          m_pi[k] = ((int'(req_pc) >> 2) % 16) ^ m_gh[k];
          m_pt[k] = (m_ctr[k][m_pi[k]] >= 2) ? 1 : 0;
        end
        if (upd_valid) begin
          if (upd_taken) m_ctr[k][upd_index] = (m_ctr[k][upd_index] < 3) ? m_ctr[k][upd_index] + 1 : 3;
          else           m_ctr[k][upd_index] = (m_ctr[k][upd_index] > 0) ? m_ctr[k][upd_index] - 1 : 0;
          if (hist_len[k] > 0) m_gh[k] = (m_gh[k] * 2 + int'(upd_taken)) % (1 << hist_len[k]);
          if (m_su[k] < stat_max[k]) m_su[k]++;
          if (upd_taken != upd_pred && m_sm[k] < stat_max[k]) m_sm[k]++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pred_valid_g", 32'(pv0), 32'(m_pv));
    chk("pred_valid_b", 32'(pv1), 32'(m_pv));
    chk("pred_taken_g", 32'(pt0), 32'(m_pt[0]));
    chk("pred_taken_b", 32'(pt1), 32'(m_pt[1]));
    chk("pred_index_g", 32'(pi0), 32'(m_pi[0]));
    chk("pred_index_b", 32'(pi1), 32'(m_pi[1]));
    chk("ghist_g", 32'(gh0), 32'(m_gh[0]));
    chk("ghist_b", 32'(gh1), 32'(m_gh[1]));
    chk("stat_updates_g", 32'(su0), 32'(m_su[0]));
    chk("stat_mispred_g", 32'(sm0), 32'(m_sm[0]));
    chk("stat_updates_b", 32'(su1), 32'(m_su[1]));
    chk("stat_mispred_b", 32'(sm1), 32'(m_sm[1]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic rv, input logic [31:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut, input logic up);
    req_valid = rv; req_pc = pc; upd_valid = uv; upd_index = ui; upd_taken = ut; upd_pred = up;
  endtask

  task automatic chk_reset_state();
    chk("rst_pred_valid_g", 32'(pv0), 0);
    chk("rst_pred_taken_g", 32'(pt0), 0);
    chk("rst_pred_index_g", 32'(pi0), 0);
    chk("rst_ghist_g", 32'(gh0), 0);
    chk("rst_stat_updates_g", 32'(su0), 0);
    chk("rst_stat_mispred_g", 32'(sm0), 0);
    chk("rst_pred_valid_b", 32'(pv1), 0);
    chk("rst_pred_index_b", 32'(pi1), 0);
    chk("rst_stat_updates_b", 32'(su1), 0);
  endtask

  // Async reset pulse placed mid-cycle, released before the next rising edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_state();
    #2 rst_n = 1'b1;
  endtask

  task automatic req10_check(input string name, input int exp_taken);
    setin(1, 32'h10, 0, 0, 0, 0);
    step();
    chk(name, 32'(pt1), 32'(exp_taken));
    setin(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    setin(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #5 chk_reset_state();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Cold lookup of pc 0x10: weakly not-taken, index 4.
    setin(1, 32'h10, 0, 0, 0, 0);
    step();
    chk("t1_pred_valid", 32'(pv0), 1);
    chk("t1_pred_taken", 32'(pt0), 0);
    chk("t1_pred_index_g", 32'(pi0), 4);
    chk("t1_pred_index_b", 32'(pi1), 4);
    setin(0, 0, 0, 0, 0, 0);
    step();
    chk("t1_hold_index", 32'(pi1), 4);
    chk("t1_valid_drop", 32'(pv1), 0);

    // Bimodal saturation upward and downward, no wrap.
    repeat (3) begin setin(0, 0, 1, 4, 1, 0); step(); end
    req10_check("t2_sat_taken", 1);
    chk("t2_model_ctr", 32'(m_ctr[1][4]), 3);
    repeat (4) begin setin(0, 0, 1, 4, 0, 0); step(); end
    req10_check("t2_after4_not", 0);
    chk("t2_model_ctr0", 32'(m_ctr[1][4]), 0);
    setin(0, 0, 1, 4, 0, 0); step();
    setin(0, 0, 1, 4, 1, 0); step();
    req10_check("t2_no_wrap", 0);
    setin(0, 0, 1, 4, 1, 0); step();
    req10_check("t2_climb", 1);

    // Gshare history: T,T,N -> 0110, index 4^6.
    pulse_reset();
    setin(0, 0, 1, 4, 1, 0); step();
    setin(0, 0, 1, 4, 1, 0); step();
    setin(0, 0, 1, 4, 0, 0); step();
    setin(1, 32'h10, 0, 0, 0, 0); step();
    chk("t3_ghist", 32'(gh0), 6);
    chk("t3_pred_index", 32'(pi0), 2);
    chk("t3_model_index", 32'(m_pi[0]), 2);
    setin(0, 0, 0, 0, 0, 0);

    // Same-cycle lookup and train on one entry: old value wins.
    pulse_reset();
    setin(1, 32'h10, 1, 4, 1, 0); step();
    chk("t4_same_cycle", 32'(pt1), 0);
    req10_check("t4_next_lookup", 1);

    // Statistics saturation.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      logic t;
      t = 1'($urandom_range(0, 1));
      setin(0, 0, 1, 4'($urandom_range(0, 15)), t, (i < 17) ? ~t : t);
      step();
    end
    setin(0, 0, 0, 0, 0, 0);
    chk("t5_updates_sat", 32'(su0), 15);
    chk("t5_mispred_sat", 32'(sm0), 15);
    chk("t5_updates_wide", 32'(su1), 20);
    chk("t5_mispred_wide", 32'(sm1), 17);

    // Randomized traffic with an async reset mid-stream.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        pulse_reset();
        setin(1, 32'h10, 0, 0, 0, 0); step();
        chk("t6_index_g", 32'(pi0), 4);
        chk("t6_taken_g", 32'(pt0), 0);
        chk("t6_taken_b", 32'(pt1), 0);
      end
      setin(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    setin(0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
